// File: rtl/iq_nco_pkg.sv
// Shared widths, quadrant encoding and quarter-wave table generator for iq_nco.
package iq_nco_pkg;

  localparam int unsigned PHASE_W = 32;
  localparam int unsigned CTRL_W  = 28;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned LUT_AW  = 8;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_t;

  // Half-step sample offset makes the mirrored entry for k exactly entry ~k.
  function automatic int lut_val(input int unsigned k, input int unsigned out_w,
                                 input int unsigned lut_aw);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(1 << lut_aw);
    return int'(amp * $sin(ang));
  endfunction

endpackage

// File: rtl/iq_nco_sin_lut.sv
// Registered quarter-wave sine ROM with two read ports (direct and mirrored index).
module iq_nco_sin_lut #(
  parameter int unsigned OUT_W  = iq_nco_pkg::OUT_W,
  parameter int unsigned LUT_AW = iq_nco_pkg::LUT_AW
) (
  input  logic              clk_sys,
  input  logic [LUT_AW-1:0] idx_a,
  input  logic [LUT_AW-1:0] idx_b,
  output logic [OUT_W-1:0]  data_a,
  output logic [OUT_W-1:0]  data_b
);
  import iq_nco_pkg::*;

  logic [OUT_W-1:0] rom [2**LUT_AW];

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam int V = lut_val(k, OUT_W, LUT_AW);
    assign rom[k] = V[OUT_W-1:0];
  end

  always_ff @(posedge clk_sys) begin
    data_a <= rom[idx_a];
    data_b <= rom[idx_b];
  end

endmodule

// File: rtl/iq_nco.sv
// Carrier-loop NCO: centre FCW plus shifted loop-filter correction, 3-stage cos/sin output.
// Optional address dithering via `define NCO_DITHER_EN.
module iq_nco #(
  parameter int unsigned PHASE_W = iq_nco_pkg::PHASE_W,
  parameter int unsigned CTRL_W  = iq_nco_pkg::CTRL_W,
  parameter int unsigned OUT_W   = iq_nco_pkg::OUT_W,
  parameter int unsigned LUT_AW  = iq_nco_pkg::LUT_AW,
  parameter logic [PHASE_W-1:0] FCW_CENTER = 32'd1073741824,
  parameter int unsigned CTRL_SHIFT = 4
) (
  input  logic                     clk_sys,
  input  logic                     rst_n,
  input  logic                     ce,
  input  logic signed [CTRL_W-1:0] ctrl_din,
  input  logic                     ctrl_vld,
  input  logic                     phase_clr,
  output logic [PHASE_W-1:0]       phase_out,
  output logic signed [OUT_W-1:0]  cos_out,
  output logic signed [OUT_W-1:0]  sin_out,
  output logic                     dout_vld
);
  import iq_nco_pkg::*;

  logic [PHASE_W-1:0]        phase_acc;
  logic [PHASE_W-1:0]        step;
  logic signed [CTRL_W-1:0]  ctrl_reg;
  logic signed [CTRL_W-1:0]  ctrl_eff;
  logic signed [PHASE_W-1:0] ctrl_ext;
  logic [LUT_AW+1:0]         addr_top;

  logic              s1_vld;
  quad_t             s1_q;
  logic [LUT_AW-1:0] s1_idx;
  logic              s2_vld;
  quad_t             s2_q;
  logic [OUT_W-1:0]  lut_a;
  logic [OUT_W-1:0]  lut_b;
  logic [OUT_W-1:0]  sin_val;
  logic [OUT_W-1:0]  cos_val;

  always_comb begin
    ctrl_eff = ctrl_vld ? ctrl_din : ctrl_reg;
    ctrl_ext = PHASE_W'(ctrl_eff);
    step     = FCW_CENTER + (ctrl_ext <<< CTRL_SHIFT);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      phase_acc <= '0;
      ctrl_reg  <= '0;
    end else begin
      if (ctrl_vld) ctrl_reg <= ctrl_din;
      if (phase_clr)  phase_acc <= '0;
      else if (ce)    phase_acc <= phase_acc + step;
    end
  end

  assign phase_out = phase_acc;

`ifdef NCO_DITHER_EN
  localparam int unsigned DITH_W = PHASE_W - 2 - LUT_AW;
  localparam logic [PHASE_W-1:0] DITH_MASK = {{(LUT_AW+2){1'b0}}, {DITH_W{1'b1}}};

  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] addr_phase;

  always_ff @(posedge clk_sys) begin
    if (!rst_n)  lfsr <= 16'hACE1;
    else if (ce) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end

  // Dither only perturbs the table address; the accumulator itself stays exact.
  assign addr_phase = phase_acc + (PHASE_W'(lfsr) & DITH_MASK);
  assign addr_top   = addr_phase[PHASE_W-1 -: LUT_AW+2];
`else
  assign addr_top = phase_acc[PHASE_W-1 -: LUT_AW+2];
`endif

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      s1_vld <= ce;
      s2_vld <= s1_vld;
    end
  end

  always_ff @(posedge clk_sys) begin
    s1_q   <= quad_t'(addr_top[LUT_AW+1 -: 2]);
    s1_idx <= addr_top[LUT_AW-1:0];
    s2_q   <= s1_q;
  end

  iq_nco_sin_lut #(
    .OUT_W (OUT_W),
    .LUT_AW(LUT_AW)
  ) u_lut (
    .clk_sys(clk_sys),
    .idx_a  (s1_idx),
    .idx_b  (~s1_idx),
    .data_a (lut_a),
    .data_b (lut_b)
  );

  always_comb begin
    sin_val = lut_a;
    cos_val = lut_b;
    unique case (s2_q)
      Q0: begin sin_val = lut_a;  cos_val = lut_b;  end
      Q1: begin sin_val = lut_b;  cos_val = -lut_a; end
      Q2: begin sin_val = -lut_a; cos_val = -lut_b; end
      Q3: begin sin_val = -lut_b; cos_val = lut_a;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sin_out  <= '0;
      cos_out  <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= s2_vld;
      if (s2_vld) begin
        sin_out <= sin_val;
        cos_out <= cos_val;
      end
    end
  end

endmodule

// File: doc/iq_nco.md
# iq_nco

Numerically controlled oscillator closing the IQ demodulator carrier loop. It sits directly downstream of the loop filter and takes its signed 28-bit correction word. It adds that word to a fixed centre frequency word and accumulates phase. Its output is a registered cos/sin local-oscillator pair that feeds the I/Q mixers.

## Interface
- PHASE_W, 32, phase accumulator width.
- CTRL_W, 28, loop-filter correction width.
- OUT_W, 16, signed sin/cos output width.
- LUT_AW, 8, quarter-wave table address width (256 entries).
- FCW_CENTER, 32'd1073741824, centre frequency word.
- CTRL_SHIFT, 4, left shift applied to the correction before adding it.
- clk_sys, in, 1: system clock.
- rst_n, in, 1: synchronous, active-low reset.
- ce, in, 1: sample enable; advances the accumulator and launches one output sample.
- ctrl_din, in, CTRL_W signed: correction word from the loop filter.
- ctrl_vld, in, 1: loads ctrl_din into the held correction register.
- phase_clr, in, 1: synchronous accumulator clear.
- phase_out, out, PHASE_W: current accumulator value.
- cos_out, out, OUT_W signed: cosine sample.
- sin_out, out, OUT_W signed: sine sample.
- dout_vld, out, 1: one-cycle strobe marking a valid cos_out/sin_out pair.

## Operation
- Reset values: phase_acc=0, ctrl_reg=0, pipeline valid bits=0, cos_out=0, sin_out=0, dout_vld=0, phase_out=0.
- Correction select:
  - ctrl_eff = ctrl_vld ? ctrl_din : ctrl_reg.
  - ctrl_reg <= ctrl_din whenever ctrl_vld=1, regardless of ce.
- Step: step = FCW_CENTER + (sign_extend(ctrl_eff, PHASE_W) <<< CTRL_SHIFT), truncated modulo 2^PHASE_W.
- Accumulator update:
  - On ce: phase_acc <= phase_acc + step, wrapping silently modulo 2^PHASE_W with no saturation.
  - The pre-update phase_acc is the value launched into the pipeline.
- phase_clr:
  - phase_clr=1 sets phase_acc <= 0 and has priority over ce.
  - If ce is also high in that cycle, the sample still launches with the pre-clear phase.
- Address decode from the launched phase p:
  - q = p[PHASE_W-1 -: 2].
  - idx = p[PHASE_W-3 -: LUT_AW].
  - Lower bits are truncated.
- LUT contents: L[k] = round((2^(OUT_W-1)-1) * sin(pi/2*(k+0.5)/2^LUT_AW)). The half-step offset makes the mirrored index exactly ~idx.
- Sine output by quadrant: q0 +L[idx], q1 +L[~idx], q2 −L[idx], q3 −L[~idx].
- Cosine output by quadrant: q0 +L[~idx], q1 −L[idx], q2 −L[~idx], q3 +L[idx].
- Negation never overflows, since the maximum magnitude is 2^(OUT_W-1)-1.
- Outputs hold their last values while dout_vld=0.

## Timing
- Pipeline has 3 stages: address/quadrant register, LUT read register, sign/output register.
- ce at clock edge n produces dout_vld=1 at edge n+3 with the sample for the phase launched at n.
- Throughput: one sample per cycle with continuous ce. A gap in ce produces a gap in dout_vld; there is no stall or backpressure.
- phase_out equals phase_acc and is updated at edge n+1.
- A ctrl_vld coinciding with ce affects the step taken at that same edge.
- Reset mid-operation:
  - Flushes the pipeline: in-flight samples are dropped and dout_vld=0 on the next cycle.
  - Outputs read 0 until new samples emerge, 3 cycles after the first post-reset ce.

## Configuration
- NCO_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,15,13,4; seed 16'hACE1 at reset) advances on each ce.
  - Its low (PHASE_W−2−LUT_AW) bits are added to the launched phase before truncation. This dithers the address only; phase_acc and phase_out are unaffected.
  - Latency is unchanged.
- NCO_DITHER_EN undefined: no LFSR; plain truncation.

## Structure
- Package iq_nco_pkg holds:
  - Default width constants PHASE_W, CTRL_W, OUT_W, LUT_AW.
  - Quadrant enum (Q0..Q3).
  - LUT init function computing L[k].
- Sub-module iq_nco_sin_lut: a registered quarter-wave ROM with two read ports (idx and ~idx paths), built from the package function.

## Test plan
- Reset, then ctrl=0 with continuous ce, FCW_CENTER=2^30 -> starting at edge 3:
  - sin_out = +101, +32767, −101, −32767 repeating.
  - cos_out = +32767, −101, −32767, +101 repeating.
- ctrl_din=28'sd1 pulsed with ctrl_vld, CTRL_SHIFT=4, ce high -> phase_out increments by 2^30+16 per ce, from the pulse cycle onward.
- ctrl_din=−(2^26) held -> step = 2^30−2^30 = 0; phase_out frozen; outputs constant.
- phase_acc near 2^32−1 -> wraps to the low quadrant with no glitch. Separately, ce high with phase_clr -> phase_out=0 next edge and the launched sample uses the old phase.
- ce toggled 1,0,1 -> dout_vld pattern 1,0,1 delayed 3 cycles. Separately, rst_n low mid-stream -> dout_vld=0 and outputs=0 next cycle.
- With NCO_DITHER_EN and a tiny FCW -> phase_out is identical to the non-dithered run; the sin spur level drops versus the non-dithered run.
